uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver inside Main. It adds an internal oversampling tick generator, configurable data width, parity, and one or two stop bits. Each bit is decided by a 3-sample majority vote, false starts are rejected, and parity and framing errors are flagged. It sits between the rx pin and the ALU/interface FSM and hands over one word per frame with a single-cycle done strobe.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
BAUD, 19_200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, ≥8
DATA_BITS, 8, data bits per frame, legal range 5–9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
dout  out  DATA_BITS  last received word, LSB received first
rx_done  out  1  one-cycle pulse when dout and flags update
parity_err  out  1  parity mismatch on last frame; 0 when PARITY_MODE = 0
frame_err  out  1  a stop bit was sampled low on last frame
busy  out  1  high from start-edge detection until the frame completes

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0; FSM goes to IDLE; counters clear; synchroniser flops set to 1.
- Synchroniser: rx passes through 2 flops; all logic uses the synchronised rx_s.
- Tick generator:
  - DIV = round(CLK_FREQ_HZ / (BAUD × OVERSAMPLE)); 163 at defaults.
  - Counter runs 0..DIV−1 continuously after reset.
  - tick is high for one clk when the counter equals DIV−1.
- Sample counter:
  - sc counts 0..OVERSAMPLE−1, advancing on each tick.
  - S = OVERSAMPLE/2. Samples are taken at sc = S−1, S, S+1.
  - The bit value is the majority of the 3 samples and is decided at the tick with sc = S+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on an rx_s 1→0 edge, clear sc and go to START; busy = 1.
  - START: at the decision point, majority 1 → false start, back to IDLE with busy = 0 and no strobe. Majority 0 → at sc = OVERSAMPLE−1, go to DATA with bit index 0.
  - DATA: each decision shifts into the shift register (LSB first). After DATA_BITS bits, go to PARITY if PARITY_MODE ≠ 0, otherwise STOP.
  - PARITY: the decided bit is compared with the XOR of the data bits (even) or its inverse (odd); a mismatch is latched.
  - STOP: each stop bit is decided the same way; any low stop bit latches frame error. At the decision of the last stop bit (not the end of the bit), do all of the following in one cycle:
    - load dout and both error flags
    - pulse rx_done
    - busy = 0
    - return to IDLE
  - Returning early is what lets a start edge that immediately follows the stop bit (back-to-back frames) be caught.
- Latency: rx_done occurs at ≈ (1 + DATA_BITS + P + STOP_BITS − 0.5) bit times + 3 clk after the start edge (P = 1 if parity enabled, else 0). Start alignment jitter is ≤ 1 tick.
- dout and the flags hold their values until the next rx_done. They are not updated on a false start or on reset mid-frame.
- Break (line held low): the frame completes with frame_err = 1 and dout = 0. The FSM then stays in IDLE until a new 1→0 edge; a line held low does not retrigger.
- A reset assertion mid-frame aborts immediately. After release, the receiver waits for a fresh falling edge.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - state enum rx_state_t
  - the DIV calculation function
- Sub-module uart_baud_tick (parameters CLK_FREQ_HZ, BAUD, OVERSAMPLE; ports clk, reset, tick). It replaces the standalone baud generator and is reused by the transmitter.

Test Plan:
1. Defaults (50 MHz, 19200, 8N1), bit time 52.08 µs; send 0x01 → one rx_done, dout = 0x01, parity_err = 0, frame_err = 0, busy low afterwards.
2. Back-to-back frames 0x03 then 0x20 with no idle gap → two rx_done pulses, dout = 0x03 then 0x20, no errors.
3. Low glitch of 10 µs on an idle line → busy pulses and returns to 0, no rx_done, dout unchanged.
4. PARITY_MODE = 1; send 0x07 with parity bit 1 → parity_err = 0. Send 0x07 with parity bit 0 → parity_err = 1, dout = 0x07.
5. STOP_BITS = 2; second stop bit driven low → frame_err = 1. Line held low for 2 frame times → one rx_done with dout = 0x00 and frame_err = 1, then no further strobes.
6. Assert reset = 0 mid-way through data bit 4 → all outputs 0 asynchronously. After release, a clean 0x20 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, receiver
// states and the oversampling divider calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Rounded clocks-per-tick; never below 1 so the tick can run every cycle.
  function automatic int calc_div(input int clk_freq_hz, input int baud, input int oversample);
    longint denom;
    longint div;
    denom = longint'(baud) * longint'(oversample);
    div   = (longint'(clk_freq_hz) + denom / 2) / denom;
    if (div < 1) div = 1;
    return int'(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick: one-cycle pulse every DIV clocks,
// shared by the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 19_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, false-start
// rejection, optional parity, one or two stop bits, single-cycle done strobe.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 19_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int S   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);

  logic                 rx_meta, rx_s, rx_prev;
  logic                 tick;
  rx_state_t            state, state_next;
  logic [SCW-1:0]       sc;
  logic                 s0, s1, maj;
  logic [BIW-1:0]       bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bad, stop_bad;
  logic                 fall_edge, decide, bit_end, finish, par_expected;

  uart_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall_edge    = rx_prev & ~rx_s;
  assign decide       = tick && (sc == SCW'(S + 1));
  assign bit_end      = tick && (sc == SCW'(OVERSAMPLE - 1));
  assign maj          = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign par_expected = (^shift_reg) ^ (PARITY_MODE == PAR_ODD);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The frame finishes at the last stop-bit decision, not at its end, so a
  // start edge straight after the stop bit is still seen from IDLE.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE:   if (fall_edge) state_next = START;
      START: begin
        if (decide && maj) state_next = IDLE;
        else if (bit_end)  state_next = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == BIW'(DATA_BITS - 1))
          state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_next = STOP;
      STOP: begin
        if (decide && (STOP_BITS == 1 || stop_idx)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc         <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
      stop_bad   <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state == IDLE) begin
        sc         <= '0;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        parity_bad <= 1'b0;
        stop_bad   <= 1'b0;
      end else if (tick) begin
        sc <= (sc == SCW'(OVERSAMPLE - 1)) ? '0 : sc + SCW'(1);
        if (sc == SCW'(S - 1)) s0 <= rx_s;
        if (sc == SCW'(S))     s1 <= rx_s;
        if (sc == SCW'(S + 1)) begin
          case (state)
            DATA:    shift_reg  <= {maj, shift_reg[DATA_BITS-1:1]};
            PARITY:  parity_bad <= (maj != par_expected);
            STOP:    if (!maj) stop_bad <= 1'b1;
            default: ;
          endcase
        end
        if (sc == SCW'(OVERSAMPLE - 1)) begin
          case (state)
            DATA:    bit_idx  <= bit_idx + BIW'(1);
            STOP:    stop_idx <= 1'b1;
            default: ;
          endcase
        end
      end
      if (finish) begin
        dout       <= shift_reg;
        parity_err <= parity_bad;
        frame_err  <= stop_bad | ~maj;
        rx_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver variants (8N1, 8E1, 9O2) on fast
// baud settings, checked against a frame-level reference model.
module tb_uart_rx_param;

  localparam int CLKF   = 3_200_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
  localparam int BITCLK = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxa = 1'b1, rxb = 1'b1, rxc = 1'b1;
  logic [7:0] douta, doutb;
  logic [8:0] doutc;
  logic donea, pea, fea, busya;
  logic doneb, peb, feb, busyb;
  logic donec, pec, fec, busyc;
  int cnta = 0, cntb = 0, cntc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx(rxa), .dout(douta), .rx_done(donea),
    .parity_err(pea), .frame_err(fea), .busy(busya));

  uart_rx_param #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .rx(rxb), .dout(doutb), .rx_done(doneb),
    .parity_err(peb), .frame_err(feb), .busy(busyb));

  uart_rx_param #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .rx(rxc), .dout(doutc), .rx_done(donec),
    .parity_err(pec), .frame_err(fec), .busy(busyc));

  always @(posedge clk) begin
    if (donea) cnta <= cnta + 1;
    if (doneb) cntb <= cntb + 1;
    if (donec) cntc <= cntc + 1;
  end

  function automatic int ndata_of(input int sel);
    return (sel == 2) ? 9 : 8;
  endfunction

  function automatic int mode_of(input int sel);
    return (sel == 0) ? 0 : (sel == 1) ? 1 : 2;
  endfunction

  function automatic int nstop_of(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction

  // Reference model: the parity bit a correct transmitter would send.
  function automatic int exp_parity(input int sel, input int data);
    int ones;
    ones = $countones(data & ((1 << ndata_of(sel)) - 1));
    return (mode_of(sel) == 1) ? (ones % 2) : (1 - ones % 2);
  endfunction

  function automatic logic exp_perr(input int sel, input int data, input int par_bit);
    return (mode_of(sel) != 0) && (par_bit != exp_parity(sel, data));
  endfunction

  function automatic logic exp_ferr(input int sel, input logic st1, input logic st2);
    return !st1 || (nstop_of(sel) == 2 && !st2);
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rxa = v;
      1:       rxb = v;
      default: rxc = v;
    endcase
  endtask

  task automatic idle_bits(input int sel, input int n);
    set_rx(sel, 1'b1);
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic get_obs(input int sel, output logic [31:0] cnt, output logic [31:0] d,
                         output logic dn, output logic pe, output logic fe, output logic bs);
    case (sel)
      0: begin cnt = cnta; d = {24'b0, douta}; dn = donea; pe = pea; fe = fea; bs = busya; end
      1: begin cnt = cntb; d = {24'b0, doutb}; dn = doneb; pe = peb; fe = feb; bs = busyb; end
      default: begin cnt = cntc; d = {23'b0, doutc}; dn = donec; pe = pec; fe = fec; bs = busyc; end
    endcase
  endtask

  task automatic send_frame(input int sel, input int data, input int par_bit,
                            input logic st1, input logic st2);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < ndata_of(sel); i++) bits.push_back(data[i]);
    if (mode_of(sel) != 0) bits.push_back(par_bit[0]);
    bits.push_back(st1);
    if (nstop_of(sel) == 2) bits.push_back(st2);
    foreach (bits[i]) begin
      set_rx(sel, bits[i]);
      repeat (BITCLK) @(negedge clk);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] c, d;
    logic dn, pe, fe, bs;
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      get_obs(s, c, d, dn, pe, fe, bs);
      checks++; if (d !== 32'd0) begin failures++; $display("[TB] FAIL reset_dout sel=%0d got=%0h exp=0", s, d); end
      checks++; if (dn !== 1'b0) begin failures++; $display("[TB] FAIL reset_done sel=%0d got=%b exp=0", s, dn); end
      checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags sel=%0d got=%b%b exp=00", s, pe, fe); end
      checks++; if (bs !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy sel=%0d got=%b exp=0", s, bs); end
    end
    reset = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    c0 = cnta;
    send_frame(0, 'h01, 0, 1'b1, 1'b1);
    idle_bits(0, 1);
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=%0d", c, c0 + 1); end
    checks++; if (d !== 32'h01) begin failures++; $display("[TB] FAIL basic_dout got=%0h exp=01", d); end
    checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("[TB] FAIL basic_flags got=%b%b exp=00", pe, fe); end
    checks++; if (bs !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=0", bs); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    c0 = cnta;
    send_frame(0, 'h03, 0, 1'b1, 1'b1);
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1 || d !== 32'h03) begin failures++; $display("[TB] FAIL b2b_first got=%0d/%0h exp=%0d/03", c, d, c0 + 1); end
    send_frame(0, 'h20, 0, 1'b1, 1'b1);
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 2 || d !== 32'h20) begin failures++; $display("[TB] FAIL b2b_second got=%0d/%0h exp=%0d/20", c, d, c0 + 2); end
    checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("[TB] FAIL b2b_flags got=%b%b exp=00", pe, fe); end
    idle_bits(0, 1);
  endtask

  task automatic test_false_start;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    logic seen;
    c0 = cnta;
    seen = 1'b0;
    set_rx(0, 1'b0);
    repeat (6) begin @(negedge clk); seen |= busya; end
    set_rx(0, 1'b1);
    repeat (10) begin @(negedge clk); seen |= busya; end
    repeat (2 * BITCLK) @(negedge clk);
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_seen got=%b exp=1", seen); end
    checks++; if (bs !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_end got=%b exp=0", bs); end
    checks++; if (c !== c0 || d !== 32'h20) begin failures++; $display("[TB] FAIL glitch_no_done got=%0d/%0h exp=%0d/20", c, d, c0); end
  endtask

  task automatic test_parity;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    c0 = cntb;
    send_frame(1, 'h07, 1, 1'b1, 1'b1);
    get_obs(1, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1 || d !== 32'h07) begin failures++; $display("[TB] FAIL par_good_frame got=%0d/%0h exp=%0d/07", c, d, c0 + 1); end
    checks++; if (pe !== exp_perr(1, 'h07, 1)) begin failures++; $display("[TB] FAIL par_good_flag got=%b exp=0", pe); end
    idle_bits(1, 1);
    send_frame(1, 'h07, 0, 1'b1, 1'b1);
    get_obs(1, c, d, dn, pe, fe, bs);
    checks++; if (pe !== exp_perr(1, 'h07, 0)) begin failures++; $display("[TB] FAIL par_bad_flag got=%b exp=1", pe); end
    checks++; if (d !== 32'h07 || fe !== 1'b0) begin failures++; $display("[TB] FAIL par_bad_data got=%0h/%b exp=07/0", d, fe); end
    idle_bits(1, 1);
  endtask

  task automatic test_stop_break;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    int data;
    data = 'h1A5;
    c0 = cntc;
    send_frame(2, data, exp_parity(2, data), 1'b1, 1'b0);
    get_obs(2, c, d, dn, pe, fe, bs);
    checks++; if (fe !== exp_ferr(2, 1'b1, 1'b0)) begin failures++; $display("[TB] FAIL stop2_ferr got=%b exp=1", fe); end
    checks++; if (d !== 32'(data) || pe !== 1'b0) begin failures++; $display("[TB] FAIL stop2_data got=%0h/%b exp=%0h/0", d, pe, data); end
    idle_bits(2, 2);
    c0 = cntc;
    set_rx(2, 1'b0);
    repeat (26 * BITCLK) @(negedge clk);
    get_obs(2, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1) begin failures++; $display("[TB] FAIL break_count got=%0d exp=%0d", c, c0 + 1); end
    checks++; if (d !== 32'd0 || fe !== 1'b1) begin failures++; $display("[TB] FAIL break_frame got=%0h/%b exp=0/1", d, fe); end
    checks++; if (pe !== exp_perr(2, 0, 0)) begin failures++; $display("[TB] FAIL break_perr got=%b exp=%b", pe, exp_perr(2, 0, 0)); end
    idle_bits(2, 4);
    get_obs(2, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1 || bs !== 1'b0) begin failures++; $display("[TB] FAIL break_no_retrigger got=%0d/%b exp=%0d/0", c, bs, c0 + 1); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    int data;
    data = 'h20;
    set_rx(0, 1'b0);
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, data[i]);
      repeat (BITCLK) @(negedge clk);
    end
    set_rx(0, data[4]);
    repeat (BITCLK / 2) @(negedge clk);
    checks++; if (busya !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before got=%b exp=1", busya); end
    reset = 1'b0;
    #1;
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (d !== 32'd0 || bs !== 1'b0 || dn !== 1'b0 || pe !== 1'b0 || fe !== 1'b0)
      begin failures++; $display("[TB] FAIL midrst_outputs got=%0h/%b%b%b%b exp=0/0000", d, bs, dn, pe, fe); end
    @(negedge clk);
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bits(0, 2);
    c0 = cnta;
    send_frame(0, data, 0, 1'b1, 1'b1);
    get_obs(0, c, d, dn, pe, fe, bs);
    checks++; if (c !== c0 + 1 || d !== 32'h20 || pe !== 1'b0 || fe !== 1'b0)
      begin failures++; $display("[TB] FAIL midrst_recover got=%0d/%0h/%b%b exp=%0d/20/00", c, d, pe, fe, c0 + 1); end
    idle_bits(0, 1);
  endtask

  task automatic test_random;
    logic [31:0] c0, c, d;
    logic dn, pe, fe, bs;
    int data, par_bit, gap;
    logic st1, st2;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 8; n++) begin
        data    = int'($urandom_range(0, (1 << ndata_of(s)) - 1));
        par_bit = exp_parity(s, data) ^ int'($urandom_range(0, 3) == 0);
        st1     = ($urandom_range(0, 4) != 0);
        st2     = (nstop_of(s) == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
        get_obs(s, c0, d, dn, pe, fe, bs);
        send_frame(s, data, par_bit, st1, st2);
        get_obs(s, c, d, dn, pe, fe, bs);
        checks++; if (c !== c0 + 1) begin failures++; $display("[TB] FAIL rand_count sel=%0d got=%0d exp=%0d", s, c, c0 + 1); end
        checks++; if (d !== 32'(data)) begin failures++; $display("[TB] FAIL rand_dout sel=%0d got=%0h exp=%0h", s, d, data); end
        checks++; if (pe !== exp_perr(s, data, par_bit)) begin failures++; $display("[TB] FAIL rand_perr sel=%0d got=%b exp=%b", s, pe, exp_perr(s, data, par_bit)); end
        checks++; if (fe !== exp_ferr(s, st1, st2)) begin failures++; $display("[TB] FAIL rand_ferr sel=%0d got=%b exp=%b", s, fe, exp_ferr(s, st1, st2)); end
        gap = (!st1 || !st2) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
        idle_bits(s, gap);
      end
      idle_bits(s, 1);
      checks++; if (busya !== 1'b0 || busyb !== 1'b0 || busyc !== 1'b0)
        begin failures++; $display("[TB] FAIL rand_idle_busy got=%b%b%b exp=000", busya, busyb, busyc); end
    end
  endtask

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_false_start();
    test_parity();
    test_stop_break();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
